// File: rtl/jedro_1_defines.sv
// jedro_1_defines: shared types and constants for the jedro_1 memory arbiter.
package jedro_1_defines;
  typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} mem_owner_e;
  localparam int STREAK_W = 4;
endpackage

// File: rtl/jedro_1_mem_arbiter.sv
// jedro_1_mem_arbiter: shares one 1-cycle-latency RAM between fetch and load/store,
// data first, with a streak limiter so fetch always makes progress.
module jedro_1_mem_arbiter
  import jedro_1_defines::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_en_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_DATA_STREAK);
  logic [STREAK_W-1:0] streak_q, streak_d;
  mem_owner_e          owner_q, owner_d;
  logic                instr_gnt, data_gnt;
  // Grants are masked while in reset so the RAM sees no access and no write.
  always_comb begin
    data_gnt  = rstn_i && data_req_i && (!instr_req_i || streak_q < MAX_S);
    instr_gnt = rstn_i && instr_req_i && !data_gnt;
    owner_d   = data_gnt ? OWN_DATA : instr_gnt ? OWN_INSTR : OWN_NONE;
    streak_d  = (!instr_req_i || instr_gnt) ? '0 :
                (data_gnt && streak_q < MAX_S) ? streak_q + 1'b1 : streak_q;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end
  assign instr_gnt_o    = instr_gnt;
  assign data_gnt_o     = data_gnt;
  assign mem_en_o       = instr_gnt || data_gnt;
  assign mem_we_o       = (data_gnt && data_we_i) ? data_be_i : '0;
  assign mem_addr_o     = instr_gnt ? instr_addr_i : data_addr_i;
  assign mem_wdata_o    = data_wdata_i;
  assign instr_rvalid_o = owner_q == OWN_INSTR;
  assign data_rvalid_o  = owner_q == OWN_DATA;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
endmodule
